// File: rtl/fetch_stage_if.sv
// Decode-facing valid/ready link carrying {pc, inst, fetch_misaligned} packets.
interface inst_packet_if;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_misaligned;
  } inst_packet_t;

  logic         valid;
  logic         ready;
  inst_packet_t inst_packet;

  modport master (output valid, output inst_packet, input ready);
  modport out    (output valid, output inst_packet, input ready);
  modport slave  (input valid, input inst_packet, output ready);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: sequential PC generation, credit-limited imem reads, in-order response buffer.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect yields a single fault packet and fetch idles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  inst_packet_if.out  if_decode_out
);
  localparam int            PW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [4:0]    MAXC = 5'(MAX_INFLIGHT);
  localparam logic [3:0]    FULL = 4'(MAX_INFLIGHT);
  localparam logic [PW-1:0] LAST = PW'(MAX_INFLIGHT - 1);

  logic [31:0]   pc_q, out_pc_q;
  logic [3:0]    inflight_q, discard_q, cnt_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_q [MAX_INFLIGHT];
  logic          rst_q;
  logic          fault_q, fault_pend_q;

  logic [31:0] redirect_pc;
  logic        misaligned_redirect;
  logic [4:0]  credits;
  logic        req_fire, drop, push, out_valid, pop, fifo_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc         = i_redirect_pc;
  assign misaligned_redirect = i_redirect_pc[1:0] != 2'b00;
`else
  assign redirect_pc         = {i_redirect_pc[31:2], 2'b00};
  assign misaligned_redirect = 1'b0;
`endif

  // Outstanding requests, pending discards and buffered words all consume a credit.
  assign credits = {1'b0, inflight_q} + {1'b0, discard_q} + {1'b0, cnt_q};

  assign o_imem_req_valid = !i_rst && !rst_q && !i_redirect && !fault_q && (credits < MAXC);
  assign o_imem_req_addr  = pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign drop = i_imem_resp_valid && (discard_q != 4'd0);
  assign push = i_imem_resp_valid && (discard_q == 4'd0) && !i_redirect;

  assign out_valid = (cnt_q != 4'd0) || fault_pend_q;
  assign pop       = out_valid && if_decode_out.ready;
  assign fifo_pop  = pop && (cnt_q != 4'd0);

  assign if_decode_out.valid                        = out_valid;
  assign if_decode_out.inst_packet.pc               = out_pc_q;
  assign if_decode_out.inst_packet.inst             = fault_pend_q ? 32'h0000_0013 : fifo_q[rd_ptr_q];
  assign if_decode_out.inst_packet.fetch_misaligned = fault_pend_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q         <= RESET_PC;
      out_pc_q     <= RESET_PC;
      inflight_q   <= 4'd0;
      discard_q    <= 4'd0;
      cnt_q        <= 4'd0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rst_q        <= 1'b1;
      fault_q      <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (i_imem_resp_valid) assert (inflight_q != 4'd0 || discard_q != 4'd0);
      if (push) assert (cnt_q != FULL);
      if (i_redirect) begin
        // Everything still in flight, minus a response landing right now, must be dropped later.
        pc_q         <= redirect_pc;
        out_pc_q     <= redirect_pc;
        cnt_q        <= 4'd0;
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        inflight_q   <= 4'd0;
        discard_q    <= discard_q + inflight_q - {3'b000, i_imem_resp_valid};
        fault_q      <= misaligned_redirect;
        fault_pend_q <= misaligned_redirect;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        inflight_q <= inflight_q + {3'b000, req_fire} - {3'b000, push};
        discard_q  <= discard_q - {3'b000, drop};
        cnt_q      <= cnt_q + {3'b000, push} - {3'b000, fifo_pop};
        if (push) begin
          fifo_q[wr_ptr_q] <= i_imem_resp_data;
          wr_ptr_q         <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (fifo_pop) begin
          rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
          out_pc_q <= out_pc_q + 32'd4;
        end
        if (pop) fault_pend_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable in-order memory and a packet model.
module tb_fetch_stage;
  localparam int MAXI = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;

  inst_packet_if dec ();

  fetch_stage #(.RESET_PC(32'h0), .MAX_INFLIGHT(MAXI)) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
    .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data), .if_decode_out(dec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] eq_pc[$];
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] exp_addr = 32'h0;
  logic        rst_prev = 1'b1;
  logic        fault = 1'b0;
  logic        fault_pend = 1'b0;
  logic [31:0] fault_pc = 32'h0;
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_pc, s_inst, s_addr;
  int          s_out;
  event        mon_ev;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory + reference model, evaluated mid-cycle; snapshot describes what the DUT must show now.
  always @(negedge clk) begin
    int infl, disc;
    mreq_t m;
    logic mis;
    infl = 0;
    disc = 0;
    foreach (mq[i]) if (mq[i].ep == epoch) infl++; else disc++;
    s_out   = infl;
    s_req   = !rst && !rst_prev && !redirect && !fault && (infl + disc + eq_pc.size() < MAXI);
    s_addr  = exp_addr;
    s_valid = fault_pend || (eq_pc.size() != 0);
    s_mis   = fault_pend;
    if (fault_pend) begin
      s_pc = fault_pc; s_inst = 32'h0000_0013;
    end else if (eq_pc.size() != 0) begin
      s_pc = eq_pc[0]; s_inst = memf(eq_pc[0]);
    end else begin
      s_pc = 32'h0; s_inst = 32'h0;
    end
    ->mon_ev;
    if (rst) begin
      mq.delete(); eq_pc.delete();
      exp_addr = 32'h0; fault = 1'b0; fault_pend = 1'b0;
      resp_valid = 1'b0; resp_data = 32'h0;
    end else begin
      if (dec.valid === 1'b1 && dec.ready && !redirect) begin
        if (fault_pend) fault_pend = 1'b0;
        else if (eq_pc.size() != 0) void'(eq_pc.pop_front());
      end
      if (req_valid === 1'b1 && req_ready) begin
        mq.push_back('{req_addr, cyc + lat, epoch});
        exp_addr = exp_addr + 32'd4;
      end
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        resp_valid = 1'b1;
        resp_data  = memf(m.addr);
        if (m.ep == epoch && !redirect) eq_pc.push_back(m.addr);
      end else begin
        resp_valid = 1'b0;
        resp_data  = 32'h0;
      end
      if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        mis = redirect_pc[1:0] != 2'b00;
        exp_addr = redirect_pc;
`else
        mis = 1'b0;
        exp_addr = {redirect_pc[31:2], 2'b00};
`endif
        epoch++;
        eq_pc.delete();
        fault = mis; fault_pend = mis; fault_pc = exp_addr;
      end
    end
    rst_prev = rst;
    cyc++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; dec.ready = 1'b1; req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== 2'b00) begin
        bad++; $display("FAIL reset_outputs got=%b exp=00", {req_valid, dec.valid});
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(mon_ev);
    total++;
    if ({req_valid, dec.valid} !== 2'b00) begin
      bad++; $display("FAIL post_reset_outputs got=%b exp=00", {req_valid, dec.valid});
    end
    @(mon_ev);
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int pops = 0;
    logic [31:0] exp_pc = 32'h0;
    lat = 1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== {s_req, s_valid}) begin
        bad++; $display("FAIL stream_ctl c=%0d got=%b exp=%b", c, {req_valid, dec.valid}, {s_req, s_valid});
      end
      if (dec.valid === 1'b1) begin
        if (first < 0) first = c;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst} !== {exp_pc, memf(exp_pc)}) begin
          bad++; $display("FAIL stream_pkt got=%h/%h exp=%h/%h", dec.inst_packet.pc,
                          dec.inst_packet.inst, exp_pc, memf(exp_pc));
        end
        exp_pc += 4;
        pops++;
      end
    end
    total++;
    if (first != 3) begin
      bad++; $display("FAIL stream_first_valid got=%0d exp=3", first);
    end
    total++;
    if (pops < 15) begin
      bad++; $display("FAIL stream_count got=%0d exp>=15", pops);
    end
  endtask

  task automatic test_latency3();
    int fires = 0;
    logic [31:0] exp_pc = 32'h0;
    lat = 3;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== {s_req, s_valid}) begin
        bad++; $display("FAIL lat3_ctl c=%0d got=%b exp=%b", c, {req_valid, dec.valid}, {s_req, s_valid});
      end
      if (req_valid === 1'b1) begin
        fires++;
        total++;
        if (req_addr !== s_addr) begin
          bad++; $display("FAIL lat3_addr got=%h exp=%h", req_addr, s_addr);
        end
      end
      if (dec.valid === 1'b1) begin
        total++;
        if (dec.inst_packet.pc !== exp_pc) begin
          bad++; $display("FAIL lat3_pc got=%h exp=%h", dec.inst_packet.pc, exp_pc);
        end
        exp_pc += 4;
      end
    end
    total++;
    if (fires < 10 || fires > 20) begin
      bad++; $display("FAIL lat3_duty got=%0d exp=10..20", fires);
    end
  endtask

  task automatic test_stall();
    int pops = 0;
    int guard = 0;
    logic [31:0] exp_pc = 32'h0;
    lat = 1;
    do_reset();
    while (pops < 2 && guard < 20) begin
      @(mon_ev);
      guard++;
      if (dec.valid === 1'b1) begin
        total++;
        if (dec.inst_packet.pc !== exp_pc) begin
          bad++; $display("FAIL stall_pre_pc got=%h exp=%h", dec.inst_packet.pc, exp_pc);
        end
        exp_pc += 4; pops++;
      end
    end
    total++;
    if (pops != 2) begin
      bad++; $display("FAIL stall_pre_timeout got=%0d exp=2", pops);
    end
    @(posedge clk); #1 dec.ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== {s_req, s_valid}) begin
        bad++; $display("FAIL stall_ctl i=%0d got=%b exp=%b", i, {req_valid, dec.valid}, {s_req, s_valid});
      end
      if (i >= 4) begin
        total++;
        if ({req_valid, dec.valid, dec.inst_packet.pc, dec.inst_packet.inst} !==
            {1'b0, 1'b1, 32'h8, memf(32'h8)}) begin
          bad++; $display("FAIL stall_hold i=%0d got=%b%b/%h exp=01/00000008", i, req_valid,
                          dec.valid, dec.inst_packet.pc);
        end
      end
    end
    @(posedge clk); #1 dec.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(mon_ev);
      if (i < 2) begin
        total++;
        if (dec.valid !== 1'b1) begin
          bad++; $display("FAIL stall_release_valid i=%0d got=%b exp=1", i, dec.valid);
        end
      end
      if (dec.valid === 1'b1) begin
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst} !== {exp_pc, memf(exp_pc)}) begin
          bad++; $display("FAIL stall_release_pc got=%h exp=%h", dec.inst_packet.pc, exp_pc);
        end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_redirect();
    int guard = 0;
    logic seen = 1'b0;
    lat = 3;
    do_reset();
    do begin
      @(mon_ev); guard++;
    end while (s_out != 2 && guard < 20);
    total++;
    if (s_out != 2) begin
      bad++; $display("FAIL redir_setup got=%0d exp=2", s_out);
    end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100;
    @(mon_ev);
    total++;
    if (req_valid !== 1'b0) begin
      bad++; $display("FAIL redir_no_req got=%b exp=0", req_valid);
    end
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== {s_req, s_valid}) begin
        bad++; $display("FAIL redir_ctl got=%b exp=%b", {req_valid, dec.valid}, {s_req, s_valid});
      end
      if (dec.valid === 1'b1) begin
        seen = 1'b1;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst} !== {32'h100, memf(32'h100)}) begin
          bad++; $display("FAIL redir_pkt got=%h/%h exp=00000100/%h", dec.inst_packet.pc,
                          dec.inst_packet.inst, memf(32'h100));
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL redir_timeout got=none exp=packet"); end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_pc = 32'h400;
    @(posedge clk); #1 redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(mon_ev);
      if (dec.valid === 1'b1) begin
        seen = 1'b1;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst} !== {32'h400, memf(32'h400)}) begin
          bad++; $display("FAIL b2b_redir_pkt got=%h exp=00000400", dec.inst_packet.pc);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_redir_timeout got=none exp=packet"); end
  endtask

  task automatic test_collide();
    logic hit = 1'b0;
    logic seen = 1'b0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      if (dec.valid === 1'b1 && mq.size() != 0 && mq[0].due <= cyc) begin
        hit = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL collide_setup got=none exp=collision"); end
    @(mon_ev);
    total++;
    if ({req_valid, dec.valid} !== 2'b01) begin
      bad++; $display("FAIL collide_cycle got=%b exp=01", {req_valid, dec.valid});
    end
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(mon_ev);
      total++;
      if ({req_valid, dec.valid} !== {s_req, s_valid}) begin
        bad++; $display("FAIL collide_ctl got=%b exp=%b", {req_valid, dec.valid}, {s_req, s_valid});
      end
      if (dec.valid === 1'b1) begin
        seen = 1'b1;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst} !== {32'h40, memf(32'h40)}) begin
          bad++; $display("FAIL collide_pkt got=%h/%h exp=00000040/%h", dec.inst_packet.pc,
                          dec.inst_packet.inst, memf(32'h40));
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL collide_timeout got=none exp=packet"); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int faults = 0;
    int fires = 0;
    logic seen = 1'b0;
    lat = 1;
    do_reset();
    repeat (5) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(mon_ev);
      if (req_valid === 1'b1) fires++;
      if (dec.valid === 1'b1) begin
        faults++;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.inst, dec.inst_packet.fetch_misaligned} !==
            {32'h102, 32'h0000_0013, 1'b1}) begin
          bad++; $display("FAIL misalign_pkt got=%h/%h/%b exp=00000102/00000013/1",
                          dec.inst_packet.pc, dec.inst_packet.inst, dec.inst_packet.fetch_misaligned);
        end
      end
    end
    total++;
    if (faults != 1 || fires != 0) begin
      bad++; $display("FAIL misalign_silence got=%0d/%0d exp=1/0", faults, fires);
    end
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(mon_ev);
      if (dec.valid === 1'b1) begin
        seen = 1'b1;
        total++;
        if ({dec.inst_packet.pc, dec.inst_packet.fetch_misaligned} !== {32'h200, 1'b0}) begin
          bad++; $display("FAIL misalign_resume got=%h exp=00000200", dec.inst_packet.pc);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL misalign_resume_timeout got=none exp=packet"); end
  endtask
`endif

  initial begin
    dec.ready = 1'b1;
    test_reset();
    test_stream();
    test_latency3();
    test_stall();
    test_redirect();
    test_collide();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
